// File: rtl/midi_msg_rx.sv
// MIDI serial receiver (8N1) with message assembler for channel, system-common and realtime bytes.
// Define MIDI_RUNNING_STATUS_EN to let data bytes that follow a complete channel message reuse its status.
module midi_msg_rx #(
  parameter int unsigned CLKS_PER_BIT = 3200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       midi_rx,
  output logic       msg_valid,
  output logic [7:0] status,
  output logic [7:0] data1,
  output logic [7:0] data2,
  output logic [1:0] byte_cnt,
  output logic       rt_valid,
  output logic [7:0] rt_byte,
  output logic       framing_err
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

`ifdef MIDI_RUNNING_STATUS_EN
  localparam logic RS_EN = 1'b1;
`else
  localparam logic RS_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_sync;
  logic             w_rx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             w_byte_ok;
  logic             w_ferr;

  logic [7:0]       r_act;
  logic [1:0]       r_need;
  logic             r_idx;
  logic [7:0]       r_d1;

  // Data bytes expected after a status byte; 0 means nothing is collected.
  function automatic logic [1:0] f_need(input logic [7:0] b);
    logic [1:0] n;
    n = 2'd0;
    if (b >= 8'h80 && b <= 8'hBF)      n = 2'd2;
    else if (b >= 8'hC0 && b <= 8'hDF) n = 2'd1;
    else if (b >= 8'hE0 && b <= 8'hEF) n = 2'd2;
    else if (b == 8'hF1 || b == 8'hF3) n = 2'd1;
    else if (b == 8'hF2)               n = 2'd2;
    return n;
  endfunction

  assign w_rx = r_sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync  <= 2'b11;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_sync  <= {r_sync[0], midi_rx};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Bit-level receive FSM: mid-bit sampling from the start edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_byte_ok   = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_bit_nxt = '0;
        if (!w_rx) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_cnt == HALF_CNT) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_rx ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == FULL_CNT) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == FULL_CNT) begin
          w_cnt_nxt = '0;
          if (w_rx) begin
            w_byte_ok   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        w_cnt_nxt = '0;
        if (w_rx) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Message assembler; realtime bytes bypass the in-progress message entirely.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msg_valid   <= 1'b0;
      status      <= '0;
      data1       <= '0;
      data2       <= '0;
      byte_cnt    <= '0;
      rt_valid    <= 1'b0;
      rt_byte     <= '0;
      framing_err <= 1'b0;
      r_act       <= '0;
      r_need      <= '0;
      r_idx       <= 1'b0;
      r_d1        <= '0;
    end else begin
      msg_valid   <= 1'b0;
      rt_valid    <= 1'b0;
      framing_err <= w_ferr;
      if (w_byte_ok) begin
        if (r_shift >= 8'hF8) begin
          rt_valid <= 1'b1;
          rt_byte  <= r_shift;
        end else if (r_shift[7]) begin
          r_act  <= r_shift;
          r_need <= f_need(r_shift);
          r_idx  <= 1'b0;
          if (r_shift == 8'hF6) begin
            msg_valid <= 1'b1;
            status    <= r_shift;
            data1     <= '0;
            data2     <= '0;
            byte_cnt  <= 2'd1;
          end
        end else if (r_need != 2'd0) begin
          if (!r_idx && r_need == 2'd2) begin
            r_d1  <= r_shift;
            r_idx <= 1'b1;
          end else begin
            msg_valid <= 1'b1;
            status    <= r_act;
            data1     <= r_idx ? r_d1 : r_shift;
            data2     <= r_idx ? r_shift : 8'h00;
            byte_cnt  <= r_idx ? 2'd3 : 2'd2;
            r_idx     <= 1'b0;
            if (!(RS_EN && r_act < 8'hF0)) r_need <= 2'd0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_msg_rx.sv
// Self-checking bench for midi_msg_rx: directed scenarios plus random byte streams vs a message-level model.
module tb_midi_msg_rx;
  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       midi_rx = 1'b1;
  logic       msg_valid, rt_valid, framing_err;
  logic [7:0] status, data1, data2, rt_byte;
  logic [1:0] byte_cnt;

  midi_msg_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .midi_rx(midi_rx),
    .msg_valid(msg_valid), .status(status), .data1(data1), .data2(data2),
    .byte_cnt(byte_cnt), .rt_valid(rt_valid), .rt_byte(rt_byte),
    .framing_err(framing_err)
  );

  always #5 clk = ~clk;

  typedef logic [25:0] rec_t;

  int checks = 0;
  int errors = 0;
  rec_t       q_msg[$], q_msg_exp[$];
  logic [7:0] q_rt[$], q_rt_exp[$];
  int ferr_seen = 0, ferr_exp = 0, dbl_pulse = 0;
  logic prev_mv = 1'b0, prev_rv = 1'b0;

  // Reference model state: bytes of the message being collected.
  logic [7:0] m_pend[$];
  int         m_len = 0;
  rec_t       m_last = '0;
  logic [7:0] m_last_rt = '0;

  always @(negedge clk) begin
    if (msg_valid) q_msg.push_back({status, data1, data2, byte_cnt});
    if (rt_valid) q_rt.push_back(rt_byte);
    if (framing_err) ferr_seen++;
    if ((msg_valid && prev_mv) || (rt_valid && prev_rv)) dbl_pulse++;
    prev_mv = msg_valid;
    prev_rv = rt_valid;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int msg_len(input logic [7:0] b);
    if (b >= 8'h80 && b <= 8'hBF) return 3;
    if (b >= 8'hC0 && b <= 8'hDF) return 2;
    if (b >= 8'hE0 && b <= 8'hEF) return 3;
    if (b == 8'hF1 || b == 8'hF3) return 2;
    if (b == 8'hF2) return 3;
    if (b == 8'hF6) return 1;
    return 0;
  endfunction

  task automatic model_emit();
    rec_t r;
    r = {m_pend[0],
         (m_pend.size() > 1) ? m_pend[1] : 8'h00,
         (m_pend.size() > 2) ? m_pend[2] : 8'h00,
         2'(m_pend.size())};
    q_msg_exp.push_back(r);
    m_last = r;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] st;
    bit rs;
`ifdef MIDI_RUNNING_STATUS_EN
    rs = 1'b1;
`else
    rs = 1'b0;
`endif
    if (b >= 8'hF8) begin
      q_rt_exp.push_back(b);
      m_last_rt = b;
    end else if (b[7]) begin
      m_pend.delete();
      m_len = msg_len(b);
      if (m_len > 0) m_pend.push_back(b);
      if (m_len == 1) begin
        model_emit();
        m_pend.delete();
      end
    end else if (m_pend.size() > 0) begin
      m_pend.push_back(b);
      if (m_pend.size() == m_len) begin
        model_emit();
        st = m_pend[0];
        m_pend.delete();
        if (rs && st < 8'hF0) m_pend.push_back(st);
      end
    end
  endtask

  task automatic model_reset();
    m_pend.delete();
    m_len = 0;
    m_last = '0;
    m_last_rt = '0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_hi);
    midi_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      midi_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    midi_rx = stop_hi;
    repeat (CPB) @(negedge clk);
    midi_rx = 1'b1;
    repeat (CPB) @(negedge clk);
    if (stop_hi) model_byte(b);
    else ferr_exp++;
  endtask

  task automatic verify(input string tag);
    rec_t obs;
    logic [7:0] ort;
    repeat (40) @(negedge clk);
    chk({tag, " msg_count"}, q_msg.size(), q_msg_exp.size());
    for (int i = 0; i < q_msg_exp.size(); i++) begin
      obs = (i < q_msg.size()) ? q_msg[i] : '1;
      chk({tag, " msg"}, obs, q_msg_exp[i]);
    end
    chk({tag, " rt_count"}, q_rt.size(), q_rt_exp.size());
    for (int i = 0; i < q_rt_exp.size(); i++) begin
      ort = (i < q_rt.size()) ? q_rt[i] : 8'hxx;
      chk({tag, " rt_byte"}, ort, q_rt_exp[i]);
    end
    chk({tag, " framing_err_count"}, ferr_seen, ferr_exp);
    chk({tag, " pulse_width"}, dbl_pulse, 0);
    chk({tag, " held_msg"}, {status, data1, data2, byte_cnt}, m_last);
    chk({tag, " held_rt"}, rt_byte, m_last_rt);
    q_msg.delete(); q_msg_exp.delete();
    q_rt.delete();  q_rt_exp.delete();
    ferr_seen = 0; ferr_exp = 0; dbl_pulse = 0;
  endtask

  initial begin
    logic [7:0] b;
    int r;

    repeat (5) @(negedge clk);
    chk("reset msg_valid", msg_valid, 1'b0);
    chk("reset status", status, 8'h00);
    chk("reset data1", data1, 8'h00);
    chk("reset data2", data2, 8'h00);
    chk("reset byte_cnt", byte_cnt, 2'd0);
    chk("reset rt_valid", rt_valid, 1'b0);
    chk("reset rt_byte", rt_byte, 8'h00);
    chk("reset framing_err", framing_err, 1'b0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    send_byte(8'hB0, 1); send_byte(8'h2E, 1); send_byte(8'h7F, 1);
    verify("cc3");
    send_byte(8'hC0, 1); send_byte(8'h42, 1); send_byte(8'hF8, 1);
    verify("pc_then_rt");
    send_byte(8'h90, 1); send_byte(8'h3C, 1); send_byte(8'hF8, 1); send_byte(8'h40, 1);
    verify("rt_mid_msg");

    send_byte(8'h90, 1); send_byte(8'h3C, 1); send_byte(8'h40, 1);
    send_byte(8'h3E, 1); send_byte(8'h00, 1);
    repeat (40) @(negedge clk);
`ifdef MIDI_RUNNING_STATUS_EN
    chk("running_status msgs", q_msg.size(), 2);
`else
    chk("running_status msgs", q_msg.size(), 1);
`endif
    verify("running_status");

    send_byte(8'h55, 0); send_byte(8'hF6, 1);
    verify("framing_then_f6");
    send_byte(8'hF0, 1); send_byte(8'h01, 1); send_byte(8'h02, 1); send_byte(8'hF7, 1);
    send_byte(8'h12, 1); send_byte(8'hF2, 1); send_byte(8'h05, 1); send_byte(8'h06, 1);
    verify("sysex_songpos");

    midi_rx = 1'b0;
    repeat (4) @(negedge clk);
    midi_rx = 1'b1;
    repeat (40) @(negedge clk);
    send_byte(8'hB0, 1);
    midi_rx = 1'b0;
    repeat (CPB * 4) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    midi_rx = 1'b1;
    model_reset();
    rst = 1'b1;
    verify("glitch_reset");
    send_byte(8'hB0, 1); send_byte(8'h2E, 1); send_byte(8'h7F, 1);
    verify("after_reset");

    for (int c = 0; c < 10; c++) begin
      for (int k = 0; k < 20; k++) begin
        r = int'($urandom_range(0, 99));
        if (r < 45)      send_byte(8'($urandom_range(0, 127)), 1);
        else if (r < 68) send_byte(8'($urandom_range(8'h80, 8'hEF)), 1);
        else if (r < 78) send_byte(8'($urandom_range(8'hF0, 8'hF7)), 1);
        else if (r < 92) send_byte(8'($urandom_range(8'hF8, 8'hFF)), 1);
        else begin
          b = 8'($urandom);
          send_byte(b, 0);
        end
      end
      verify("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
